multi_rate_clkgen: RTL and testbench

Parametrised, N-channel clock/strobe generator driven from the 100 MHz board clock. Each channel produces a 50 %-duty square wave and an optional one-cycle rising-edge tick. The channel's half-period is programmable at run time and applied glitch-free. It replaces the fixed 1 Hz / 1 kHz divider and feeds display multiplexing, debounce sampling and timekeeping logic.

---
 rtl/clkgen_pkg.sv | 50 +++++
 rtl/multi_rate_clkgen_channel.sv | 165 ++++++++++++++++
 rtl/multi_rate_clkgen.sv | 67 ++++++
 tb/tb_multi_rate_clkgen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_pkg
//
// Purpose : Shared types and constants for the multi-rate clock/strobe
//           generator. Holds the default counter width, the standard
//           half-period constants for the board's 100 MHz clock and a small
//           helper that maps a named rate onto its half-period.
//
// Contents:
//   CNT_W_DEF   default counter/divisor width (27 bits holds 50_000_000)
//   div_t       half-period type at the default width
//   HALF_1HZ    half-period for a 1 Hz output
//   HALF_100HZ  half-period for a 100 Hz output
//   HALF_1KHZ   half-period for a 1 kHz output
//   rate_e      named standard rates
//   rate_half() rate_e -> half-period in clk_100MHz cycles
// -----------------------------------------------------------------------------
package clkgen_pkg;

    localparam int CNT_W_DEF = 27;

    typedef logic [CNT_W_DEF-1:0] div_t;

    // Half-periods in cycles of the 100 MHz clock: f_out = 100e6 / (2 * H).
    localparam int HALF_1HZ   = 50_000_000;
    localparam int HALF_100HZ = 500_000;
    localparam int HALF_1KHZ  = 50_000;

    typedef enum logic [1:0] {
        RATE_1HZ   = 2'd0,
        RATE_100HZ = 2'd1,
        RATE_1KHZ  = 2'd2,
        RATE_PARK  = 2'd3
    } rate_e;

    // Convenience for software-facing register maps and for callers that
    // want a named rate rather than a raw cycle count. RATE_PARK maps to a
    // half-period of zero, which parks the channel low.
    function automatic div_t rate_half(input rate_e rate);
        div_t half;
        case (rate)
            RATE_1HZ:   half = div_t'(HALF_1HZ);
            RATE_100HZ: half = div_t'(HALF_100HZ);
            RATE_1KHZ:  half = div_t'(HALF_1KHZ);
            default:    half = '0;
        endcase
        return half;
    endfunction

endpackage : clkgen_pkg

// File: rtl/multi_rate_clkgen_channel.sv
// -----------------------------------------------------------------------------
// clkgen_channel
//
// Purpose : One output channel of the multi-rate clock generator. A counter
//           runs 0..H-1 and toggles a 50 %-duty square wave at every wrap.
//           A run-time half-period can be staged (pending) and is swapped in
//           only at a toggle boundary, so no output phase is ever shortened
//           or stretched beyond old-H followed by new-H.
//
// Build option:
//   CLKGEN_TICK_EN  defined   -> tick_o is a registered one-cycle pulse that
//                                coincides with every clk_out_o rising edge.
//                   undefined -> tick_o is tied low and has no flop.
//
// Ports:
//   clk_100MHz   in   1      system clock
//   rst_n        in   1      synchronous active-low reset
//   en_i         in   1      channel enable (level); low forces output low
//   load_i       in   1      strobe: stage div_half_i as pending half-period
//   sync_i       in   1      strobe: restart phase at zero, low output
//   div_half_i   in   CNT_W  requested half-period in clk cycles (0 = park)
//   clk_out_o    out  1      divided square wave (registered)
//   tick_o       out  1      one-cycle pulse on clk_out_o rising edge
// -----------------------------------------------------------------------------
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = HALF_1HZ
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             sync_i,
    input  logic [CNT_W-1:0] div_half_i,
    output logic             clk_out_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q,  cnt_d;    // position inside current half-period
    logic [CNT_W-1:0] half_q, half_d;   // active half-period H
    logic [CNT_W-1:0] pend_half_q, pend_half_d;  // staged half-period P
    logic             pend_q, pend_d;   // P waiting for the next boundary
    logic             clk_q,  clk_d;    // output level

    logic parked;     // H == 0: channel held low until re-armed
    logic terminal;   // last cycle of the current half-period

    assign parked   = (half_q == '0);
    assign terminal = (cnt_q == half_q - ONE);

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: sync, then park, then enable, then count.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default here so that no branch leaves
        // one unassigned; an unassigned path would infer a latch.
        cnt_d       = cnt_q;
        clk_d       = clk_q;
        half_d      = half_q;
        pend_half_d = pend_half_q;
        pend_d      = pend_q;

        if (sync_i) begin
            // Phase restart. A load in the same cycle bypasses the pending
            // stage; otherwise any staged value is adopted now.
            cnt_d = '0;
            clk_d = 1'b0;
            if (load_i) begin
                half_d      = div_half_i;
                pend_half_d = div_half_i;
                pend_d      = 1'b0;
            end else if (pend_q) begin
                half_d = pend_half_q;
                pend_d = 1'b0;
            end
        end else begin
            // A load always stages; the branches below may consume it at once.
            if (load_i) begin
                pend_half_d = div_half_i;
                pend_d      = 1'b1;
            end

            if (parked) begin
                cnt_d = '0;
                clk_d = 1'b0;
                // There is no toggle boundary to wait for while parked, so a
                // non-zero load is adopted immediately.
                if (load_i && (div_half_i != '0)) begin
                    half_d = div_half_i;
                    pend_d = 1'b0;
                end
            end else if (!en_i) begin
                // Staged state is kept so the channel resumes with it.
                cnt_d = '0;
                clk_d = 1'b0;
            end else if (terminal) begin
                cnt_d = '0;
                clk_d = ~clk_q;
                // Only a value staged before this cycle is swapped in; a load
                // arriving on the boundary itself waits for the next one.
                if (pend_q && !load_i) begin
                    half_d = pend_half_q;
                    pend_d = 1'b0;
                    // Switching to H == 0 parks low straight away rather than
                    // leaving the output stuck high.
                    if (pend_half_q == '0) begin
                        clk_d = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // flop samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            cnt_q       <= '0;
            clk_q       <= 1'b0;
            half_q      <= RST_HALF;
            pend_half_q <= RST_HALF;
            pend_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            clk_q       <= clk_d;
            half_q      <= half_d;
            pend_half_q <= pend_half_d;
            pend_q      <= pend_d;
        end
    end

    assign clk_out_o = clk_q;

    // -------------------------------------------------------------------------
    // Rising-edge tick. The output only ever goes 0 -> 1 through a normal
    // toggle, so comparing next and current level is sufficient; sync,
    // disable, park and reset can only drive it low and never raise a tick.
    // -------------------------------------------------------------------------
`ifdef CLKGEN_TICK_EN
    logic tick_q;

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= clk_d & ~clk_q;
        end
    end

    assign tick_o = tick_q;
`else
    assign tick_o = 1'b0;
`endif

endmodule : clkgen_channel

// File: rtl/multi_rate_clkgen.sv
// -----------------------------------------------------------------------------
// multi_rate_clkgen
//
// Purpose : N-channel clock/strobe generator running from the 100 MHz board
//           clock. Each channel produces a 50 %-duty square wave whose
//           half-period can be reprogrammed at run time without glitches,
//           plus an optional one-cycle tick on every rising edge. Replaces
//           the fixed 1 Hz / 1 kHz dividers; consumers are display
//           multiplexing, debounce sampling and timekeeping.
//
//           This level only fans the shared load/sync strobes and the
//           per-channel enable and divisor slices out to the channels.
//
// Build option:
//   CLKGEN_TICK_EN  defined   -> tick_o pulses on each clk_out_o rising edge
//                   undefined -> tick_o is constant 0, no tick flops
//
// Parameters:
//   N_CH      number of independent output channels
//   CNT_W     counter/divisor width; must hold the largest half-period
//   DEF_HALF  half-period loaded into every channel at reset (1 Hz default)
//
// Ports:
//   clk_100MHz  in   1           system clock, 100 MHz
//   rst_n       in   1           synchronous active-low reset
//   en_i        in   N_CH        per-channel enable, level
//   div_half_i  in   N_CH*CNT_W  requested half-periods; channel k occupies
//                                bits [k*CNT_W +: CNT_W]
//   load_i      in   1           strobe: stage all div_half_i as pending
//   sync_i      in   1           strobe: restart all channels phase-aligned
//   clk_out_o   out  N_CH        divided square wave per channel
//   tick_o      out  N_CH        one-cycle pulse on each clk_out_o rise
// -----------------------------------------------------------------------------
module multi_rate_clkgen
    import clkgen_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = HALF_1HZ
) (
    input  logic                  clk_100MHz,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       en_i,
    input  logic [N_CH*CNT_W-1:0] div_half_i,
    input  logic                  load_i,
    input  logic                  sync_i,
    output logic [N_CH-1:0]       clk_out_o,
    output logic [N_CH-1:0]       tick_o
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clkgen_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_channel (
            .clk_100MHz (clk_100MHz),
            .rst_n      (rst_n),
            .en_i       (en_i[g]),
            .load_i     (load_i),
            .sync_i     (sync_i),
            .div_half_i (div_half_i[g*CNT_W +: CNT_W]),
            .clk_out_o  (clk_out_o[g]),
            .tick_o     (tick_o[g])
        );
    end

endmodule : multi_rate_clkgen

// File: tb/tb_multi_rate_clkgen.sv
// -----------------------------------------------------------------------------
// tb_multi_rate_clkgen
//
// Two-channel bench with DEF_HALF = 4 and an 8-bit divisor. A timeline model
// tracks, per channel, the cycle at which the current half-period started and
// the half-period length; the output flips when that many cycles have
// elapsed. It is compared against the DUT every cycle, and directed scenarios
// pin the model with hand-computed literal values. Expected ticks follow the
// CLKGEN_TICK_EN build option.
// -----------------------------------------------------------------------------
module tb_multi_rate_clkgen;

    localparam int N_CH  = 2;
    localparam int CNT_W = 8;
    localparam int DEF   = 4;

`ifdef CLKGEN_TICK_EN
    localparam logic TICK_ON = 1'b1;
`else
    localparam logic TICK_ON = 1'b0;
`endif

    logic                  clk_100MHz = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       en;
    logic [N_CH*CNT_W-1:0] div_half;
    logic                  load;
    logic                  sync;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;   // directed-scenario cycle index

    always #5 clk_100MHz = ~clk_100MHz;

    multi_rate_clkgen #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .en_i       (en),
        .div_half_i (div_half),
        .load_i     (load),
        .sync_i     (sync),
        .clk_out_o  (clk_out),
        .tick_o     (tick)
    );

    task automatic check(input string name, input logic [N_CH-1:0] act,
                         input logic [N_CH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N_CH-1:0] tk(input logic [N_CH-1:0] v);
        return TICK_ON ? v : '0;
    endfunction

    // ------------------------------------------------------------------
    // Timeline model
    // ------------------------------------------------------------------
    int              m_half  [N_CH];
    int              m_pend_v[N_CH];
    bit              m_pend  [N_CH];
    int              m_start [N_CH];   // first cycle of current half-period
    int              m_cyc   = 0;
    bit              m_valid = 1'b0;
    logic [N_CH-1:0] exp_clk  = '0;
    logic [N_CH-1:0] exp_tick = '0;

    task automatic model_step();
        logic [N_CH-1:0] prev;
        prev = exp_clk;
        for (int i = 0; i < N_CH; i++) begin
            int dv;
            bit stage;
            dv    = 32'(div_half[i*CNT_W +: CNT_W]);
            stage = load;
            if (!rst_n) begin
                exp_clk[i]  = 1'b0;
                m_half[i]   = DEF;
                m_pend_v[i] = DEF;
                m_pend[i]   = 1'b0;
                m_start[i]  = m_cyc + 1;
                stage       = 1'b0;
            end else if (sync) begin
                exp_clk[i] = 1'b0;
                m_start[i] = m_cyc + 1;
                if (load) begin
                    m_half[i]   = dv;
                    m_pend_v[i] = dv;
                    m_pend[i]   = 1'b0;
                end else if (m_pend[i]) begin
                    m_half[i] = m_pend_v[i];
                    m_pend[i] = 1'b0;
                end
                stage = 1'b0;
            end else if (m_half[i] == 0) begin
                exp_clk[i] = 1'b0;
                m_start[i] = m_cyc + 1;
                if (load && dv != 0) begin
                    m_half[i] = dv;
                    m_pend[i] = 1'b0;
                    stage     = 1'b0;
                end
            end else if (!en[i]) begin
                exp_clk[i] = 1'b0;
                m_start[i] = m_cyc + 1;
            end else if (m_cyc + 1 - m_start[i] == m_half[i]) begin
                // A full half-period has elapsed: flip and open a new one.
                exp_clk[i] = ~exp_clk[i];
                m_start[i] = m_cyc + 1;
                if (m_pend[i] && !load) begin
                    m_half[i] = m_pend_v[i];
                    m_pend[i] = 1'b0;
                    if (m_half[i] == 0) exp_clk[i] = 1'b0;
                end
            end
            if (stage) begin
                m_pend_v[i] = dv;
                m_pend[i]   = 1'b1;
            end
        end
        if (!rst_n) m_valid = 1'b1;
        exp_tick = exp_clk & ~prev & {N_CH{TICK_ON}};
        m_cyc++;
    endtask

    // Inputs change only on the falling edge, so one time unit after the
    // rising edge they still hold the values the DUT just sampled.
    initial begin
        forever begin
            @(posedge clk_100MHz);
            #1;
            model_step();
            if (m_valid) begin
                check($sformatf("model cyc%0d clk_out", m_cyc), clk_out, exp_clk);
                check($sformatf("model cyc%0d tick", m_cyc), tick, exp_tick);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers (all run on the falling edge)
    // ------------------------------------------------------------------
    task automatic wait_to(input int c);
        while (t < c) begin
            @(negedge clk_100MHz);
            t++;
        end
    endtask

    task automatic pulse_load(input logic [N_CH*CNT_W-1:0] dv);
        div_half = dv;
        load     = 1'b1;
        @(negedge clk_100MHz);
        t++;
        load = 1'b0;
    endtask

    // sync+load together: values apply at once, next cycle becomes t = 0.
    task automatic sync_load(input logic [N_CH*CNT_W-1:0] dv, input logic [N_CH-1:0] e);
        div_half = dv;
        load     = 1'b1;
        sync     = 1'b1;
        en       = e;
        @(negedge clk_100MHz);
        load = 1'b0;
        sync = 1'b0;
        t    = 0;
    endtask

    task automatic pin(input string name, input logic [N_CH-1:0] c_exp,
                       input logic [N_CH-1:0] t_exp);
        check($sformatf("%s t%0d clk_out", name, t), clk_out, c_exp);
        check($sformatf("%s t%0d tick", name, t), tick, tk(t_exp));
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = '0;
        div_half = '0;
        load     = 1'b0;
        sync     = 1'b0;

        // Reset state, then run at DEF_HALF = 4.
        repeat (3) @(negedge clk_100MHz);
        pin("reset", 2'b00, 2'b00);
        rst_n = 1'b1;
        en    = 2'b11;
        t     = 0;
        wait_to(3);  pin("def", 2'b00, 2'b00);
        wait_to(4);  pin("def", 2'b11, 2'b11);
        wait_to(5);  pin("def", 2'b11, 2'b00);
        wait_to(8);  pin("def", 2'b00, 2'b00);
        wait_to(12); pin("def", 2'b11, 2'b11);
        wait_to(20); pin("def", 2'b11, 2'b11);

        // H = 3, load 5 at cycle 1: half-periods 3, 5, 5.
        sync_load({8'd3, 8'd3}, 2'b11);
        wait_to(1);  pulse_load({8'd5, 8'd5});
        wait_to(2);  pin("reload", 2'b00, 2'b00);
        wait_to(3);  pin("reload", 2'b11, 2'b11);
        wait_to(7);  pin("reload", 2'b11, 2'b00);
        wait_to(8);  pin("reload", 2'b00, 2'b00);
        wait_to(12); pin("reload", 2'b00, 2'b00);
        wait_to(13); pin("reload", 2'b11, 2'b11);

        // ch0 H = 3, ch1 H = 5 started two cycles later, sync at cycle 7.
        sync_load({8'd5, 8'd3}, 2'b01);
        wait_to(2);  en = 2'b11;
        wait_to(7);  pin("sync", 2'b10, 2'b10);
        sync = 1'b1;
        wait_to(8);  sync = 1'b0;
        pin("sync", 2'b00, 2'b00);
        wait_to(10); pin("sync", 2'b00, 2'b00);
        wait_to(11); pin("sync", 2'b01, 2'b01);
        wait_to(12); pin("sync", 2'b01, 2'b00);
        wait_to(13); pin("sync", 2'b11, 2'b10);

        // Load 0 parks after next toggle; load 2 while parked restarts at once.
        sync_load({8'd4, 8'd4}, 2'b11);
        wait_to(1);  pulse_load({8'd0, 8'd0});
        wait_to(4);  pin("park", 2'b00, 2'b00);
        wait_to(9);  pin("park", 2'b00, 2'b00);
        wait_to(10); pulse_load({8'd2, 8'd2});
        wait_to(12); pin("unpark", 2'b00, 2'b00);
        wait_to(13); pin("unpark", 2'b11, 2'b11);
        wait_to(14); pin("unpark", 2'b11, 2'b00);
        wait_to(15); pin("unpark", 2'b00, 2'b00);
        wait_to(17); pin("unpark", 2'b11, 2'b11);

        // H = 4, drop ch0 enable mid-high-phase, re-enable at cycle 9.
        sync_load({8'd4, 8'd4}, 2'b11);
        wait_to(5);  pin("en", 2'b11, 2'b00);
        en = 2'b10;
        wait_to(6);  pin("en", 2'b10, 2'b00);
        wait_to(9);  en = 2'b11;
        wait_to(12); pin("en", 2'b10, 2'b10);
        wait_to(13); pin("en", 2'b11, 2'b01);

        // H = 1: toggles every cycle.
        sync_load({8'd1, 8'd1}, 2'b11);
        pin("h1", 2'b00, 2'b00);
        wait_to(1);  pin("h1", 2'b11, 2'b11);
        wait_to(2);  pin("h1", 2'b00, 2'b00);
        wait_to(3);  pin("h1", 2'b11, 2'b11);

        // Back to H = 4, stage 7 then 9 (last wins), reset before any boundary.
        sync_load({8'd4, 8'd4}, 2'b11);
        wait_to(1);  pulse_load({8'd7, 8'd7});
        pulse_load({8'd9, 8'd9});
        rst_n = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        pin("rst", 2'b00, 2'b00);
        rst_n = 1'b1;
        t     = 0;
        wait_to(4);  pin("rst", 2'b11, 2'b11);
        wait_to(8);  pin("rst", 2'b00, 2'b00);
        wait_to(12); pin("rst", 2'b11, 2'b11);
        wait_to(16); pin("rst", 2'b00, 2'b00);

        repeat (2) @(negedge clk_100MHz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched",
                 n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_multi_rate_clkgen
